hwag_sync: RTL

Parametrised successor to the HWAG crank-wheel core. It measures tooth periods on a missing-tooth trigger wheel of configurable geometry, locates the gap, and tracks tooth position. It verifies the gap on every revolution and reports gap/stall faults. It sits between the crank sensor input and the angle-generation and compare logic, supplying tooth index, last tooth period and sync status.

---
 rtl/hwag_pkg.sv | 16 +
 rtl/hwag_edge_det.sv | 27 ++
 rtl/hwag_sync.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hwag_pkg.sv
// Shared types and geometry helper for the crank-wheel synchroniser.
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    SEARCH,
    SYNC
  } hwag_state_t;

  // Index of the last physical tooth before the gap.
  function automatic int hwag_top(input int teeth_total, input int teeth_missing);
    return teeth_total - teeth_missing - 1;
  endfunction

endpackage

// File: rtl/hwag_edge_det.sv
// Two-flop synchroniser plus polarity-selected single-cycle edge pulse.
module hwag_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic cap,
  input  logic edge_sel,
  output logic pulse
);

  logic s1, s2, s3;

  // Pulse is registered so the cap-to-pulse latency is a fixed 3 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= cap;
      s2    <= s1;
      s3    <= s2;
      pulse <= edge_sel ? (s3 & ~s2) : (s2 & ~s3);
    end
  end

endmodule

// File: rtl/hwag_sync.sv
// Missing-tooth crank wheel synchroniser: tooth period measurement, gap
// detection and tooth position tracking with per-revolution gap checks.
//
// state   | meaning
// IDLE    | counter held at 0, waiting for the first edge
// MEASURE | filling the two-deep period history
// SEARCH  | history valid, looking for the gap
// SYNC    | locked, tooth_cnt tracks wheel position
module hwag_sync
  import hwag_pkg::*;
#(
  parameter int PCNT_WIDTH    = 24,
  parameter int TCNT_WIDTH    = 8,
  parameter int TEETH_TOTAL   = 60,
  parameter int TEETH_MISSING = 2,
  parameter int GAP_SHIFT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  cap,
  input  logic                  cap_edge_sel,
  output logic [TCNT_WIDTH-1:0] tooth_cnt,
  output logic [PCNT_WIDTH-1:0] tooth_period,
  output logic                  tooth_stb,
  output logic                  rev_stb,
  output logic                  sync,
  output logic                  err_gap_early,
  output logic                  err_gap_missing,
  output logic                  err_stall
);

  localparam int TOP = hwag_top(TEETH_TOTAL, TEETH_MISSING);
  localparam int CW  = PCNT_WIDTH + GAP_SHIFT;
  localparam logic [TCNT_WIDTH-1:0] TOP_C = TCNT_WIDTH'(TOP);
  localparam logic [TCNT_WIDTH-1:0] ONE_C = TCNT_WIDTH'(1);

  hwag_state_t state, state_nxt;

  logic                  e;
  logic [PCNT_WIDTH-1:0] cnt, h0, h1;
  logic [1:0]            vld;
  logic                  stall, gap, clr;
  logic [CW-1:0]         h0_x, p_sh, h1_sh;
  logic [TCNT_WIDTH-1:0] tooth_next, tc_nxt;
  logic                  stb_nxt, rev_nxt, early_nxt, missing_nxt, stall_nxt;

  hwag_edge_det u_edge (
    .clk      (clk),
    .rst      (rst),
    .cap      (cap),
    .edge_sel (cap_edge_sel),
    .pulse    (e)
  );

  assign clr   = rst | ~ena;
  assign stall = (state != IDLE) && (cnt == '1);

  // Widened so the shifted operands never lose their top bits.
  assign h0_x  = CW'(h0);
  assign p_sh  = CW'(cnt) << GAP_SHIFT;
  assign h1_sh = CW'(h1) << GAP_SHIFT;
  assign gap   = (h0_x > p_sh) && (h0_x > h1_sh);

  assign tooth_next   = (tooth_cnt == TOP_C) ? '0 : tooth_cnt + ONE_C;
  assign tooth_period = h0;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stall) begin
      state_nxt = IDLE;
    end else if (e) begin
      case (state)
        IDLE:    state_nxt = MEASURE;
        MEASURE: if (vld == 2'd1) state_nxt = SEARCH;
        SEARCH:  if (gap) state_nxt = SYNC;
        SYNC:    if (early_nxt || missing_nxt) state_nxt = SEARCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tc_nxt      = tooth_cnt;
    stb_nxt     = 1'b0;
    rev_nxt     = 1'b0;
    early_nxt   = 1'b0;
    missing_nxt = 1'b0;
    stall_nxt   = stall;
    if (stall) begin
      tc_nxt = '0;
    end else if (e) begin
      stb_nxt = (state != IDLE);
      case (state)
        SEARCH: tc_nxt = gap ? ONE_C : '0;
        SYNC: begin
          if (gap && tooth_next != ONE_C) begin
            early_nxt = 1'b1;
            tc_nxt    = '0;
          end else if (!gap && tooth_next == ONE_C) begin
            missing_nxt = 1'b1;
            tc_nxt      = '0;
          end else begin
            tc_nxt  = tooth_next;
            rev_nxt = (tooth_next == '0);
          end
        end
        default: tc_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt             <= '0;
      h0              <= '0;
      h1              <= '0;
      vld             <= '0;
      tooth_cnt       <= '0;
      tooth_stb       <= 1'b0;
      rev_stb         <= 1'b0;
      sync            <= 1'b0;
      err_gap_early   <= 1'b0;
      err_gap_missing <= 1'b0;
      err_stall       <= 1'b0;
    end else begin
      tooth_cnt       <= tc_nxt;
      tooth_stb       <= stb_nxt;
      rev_stb         <= rev_nxt;
      sync            <= (state_nxt == SYNC);
      err_gap_early   <= early_nxt;
      err_gap_missing <= missing_nxt;
      err_stall       <= stall_nxt;
      if (stall) begin
        cnt <= '0;
        h0  <= '0;
        h1  <= '0;
        vld <= '0;
      end else if (e) begin
        cnt <= PCNT_WIDTH'(1);
        if (state != IDLE) begin
          h0 <= cnt;
          h1 <= h0;
        end
        if (state == MEASURE) vld <= vld + 2'd1;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + PCNT_WIDTH'(1);
      end
    end
  end

endmodule
